// File: rtl/vec_collector_6x32_pkg.sv
// Shared sizing and slot-select type for the 6x32 result-vector collector.
package vec_collector_6x32_pkg;
  localparam int LANES  = 6;
  localparam int WIDTH  = 32;
  localparam int VEC_W  = LANES * WIDTH;
  localparam int LIDX_W = $clog2(LANES);

  typedef enum logic {SLOT_A = 1'b0, SLOT_B = 1'b1} slot_e;

  function automatic slot_e other_slot(input slot_e s);
    return (s == SLOT_A) ? SLOT_B : SLOT_A;
  endfunction
endpackage

// File: rtl/vec_collector_6x32_slot.sv
// One buffer slot: a LANES x WIDTH register bank with per-lane write enable and a full flag.
module collector_slot
  import vec_collector_6x32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [LIDX_W-1:0] wr_lane,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              set_full,
  input  logic              clr_full,
  output logic [VEC_W-1:0]  data,
  output logic              full
);

  logic [LANES-1:0] lane_we;

  always_comb begin
    lane_we = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_we[i] = wr_en && (wr_lane == LIDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i]) data[i*WIDTH +: WIDTH] <= wr_data;
      end
      // Completing a vector takes priority over a release of the same slot.
      if (set_full)      full <= 1'b1;
      else if (clr_full) full <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_collector_6x32.sv
// Packs six consecutive row results into a 192-bit vector, double-buffered behind a
// valid/ready output; words arriving with both slots full are dropped and flagged.
module vec_collector_6x32
  import vec_collector_6x32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_data,
  output logic             busy,
  output logic             overflow,
  input  logic             overflow_clr
);

  // Handshake: a vector transfers on any rising edge where out_valid && out_ready.
  // out_valid/out_data stay stable until then; out_valid never depends on out_ready.

  slot_e             wsel, rsel;
  logic [LIDX_W-1:0] widx;

  logic              full_a, full_b;
  logic [VEC_W-1:0]  data_a, data_b;

  logic rd_fire, wslot_full, wslot_blocked, accept, drop, last_lane;

  always_comb begin
    rd_fire       = out_valid && out_ready;
    wslot_full    = (wsel == SLOT_A) ? full_a : full_b;
    // A slot being released this cycle can take the incoming word as its lane 0.
    wslot_blocked = wslot_full && !(rd_fire && (rsel == wsel));
    accept        = in_valid && !flush && !wslot_blocked;
    drop          = in_valid && !flush && wslot_blocked;
    last_lane     = (widx == LIDX_W'(LANES - 1));
  end

  collector_slot u_slot_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept && (wsel == SLOT_A)),
    .wr_lane  (widx),
    .wr_data  (in_data),
    .set_full (accept && last_lane && (wsel == SLOT_A)),
    .clr_full (rd_fire && (rsel == SLOT_A)),
    .data     (data_a),
    .full     (full_a)
  );

  collector_slot u_slot_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept && (wsel == SLOT_B)),
    .wr_lane  (widx),
    .wr_data  (in_data),
    .set_full (accept && last_lane && (wsel == SLOT_B)),
    .clr_full (rd_fire && (rsel == SLOT_B)),
    .data     (data_b),
    .full     (full_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel     <= SLOT_A;
      rsel     <= SLOT_A;
      widx     <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        widx <= '0;
      end else if (accept) begin
        if (last_lane) begin
          widx <= '0;
          wsel <= other_slot(wsel);
        end else begin
          widx <= widx + 1'b1;
        end
      end
      if (rd_fire) rsel <= other_slot(rsel);
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    out_valid = (rsel == SLOT_A) ? full_a : full_b;
    out_data  = (rsel == SLOT_A) ? data_a : data_b;
    busy      = (widx != '0);
  end

endmodule

// File: doc/vec_collector_6x32.md
# vec_collector_6x32

Downstream stage of the six-input FP32 adder tree in the 6x6 matrix × 6-vector datapath. Accepts one 32-bit dot-product result per valid cycle and packs six consecutive results into a 192-bit result vector; lane 0 is the first row. The vector is presented on a valid/ready handshake to the AXI-side writer. The adder tree cannot be stalled, so the block double-buffers results and flags any result it has to drop.

## Interface
- LANES, 6, words per output vector
- WIDTH, 32, bits per word (FP32, passed through untouched)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data carries a row result this cycle, aligned by the upstream sequencer to the adder-tree latency
- in_data  in  WIDTH  row result
- flush  in  1  discard the partially filled vector
- out_valid  out  1  out_data holds a complete vector
- out_ready  in  1  consumer accepts the vector
- out_data  out  LANES*WIDTH  word i at bits [WIDTH*i +: WIDTH]
- busy  out  1  write slot holds 1..LANES-1 words
- overflow  out  1  sticky: a result was dropped
- overflow_clr  in  1  clears overflow

## Operation
- Two slots, A and B, each LANES×WIDTH with a full flag.
- Write pointer wsel: reset value A.
- Read pointer rsel: reset value A.
- Lane index widx: 0..LANES-1, reset value 0.
- Accept: in_valid && !flush && slot[wsel] not full. Writes in_data to slot[wsel] lane widx.
  - If widx == LANES-1: set slot[wsel].full, toggle wsel, widx ← 0.
  - Otherwise widx ← widx+1.
- Drop: in_valid && !flush && slot[wsel] full. Word discarded, widx unchanged, overflow ← 1.
- Release slot: a write into a slot being released in the same cycle (out_valid && out_ready, slot[rsel] == slot[wsel]) is accepted, not dropped. It writes lane 0 of the freed slot.
- Output:
  - out_valid = slot[rsel].full.
  - out_data = slot[rsel] contents.
  - On out_valid && out_ready: clear slot[rsel].full and toggle rsel.
- Stall: out_data and out_valid are held stable while out_valid && !out_ready.
- Flush:
  - widx ← 0; the partial contents are ignored and no overflow is raised.
  - Full slots are untouched.
  - If flush and in_valid are asserted together, flush wins and the word is discarded.
- Overflow:
  - overflow_clr and a drop in the same cycle: overflow stays 1.
  - overflow_clr alone: overflow ← 0.
- busy = (widx != 0).
- Reset mid-vector: all partial and full contents are abandoned. No output handshake completes for them.
- States per slot: EMPTY → FILLING (widx>0, wsel points at it) → FULL → EMPTY on handshake.

## Timing
- Reset values:
  - out_valid 0, out_data 0, busy 0, overflow 0.
  - Both full flags 0, widx 0, wsel=rsel=A.
- Latency: the 6th word sampled at edge N gives out_valid=1 in the cycle after edge N, if no older vector is pending.
- Back-to-back vectors with out_ready held high: one vector every 6 accepted words, with no bubbles required on the input.
- The input can be stalled-free indefinitely only if the consumer accepts each vector within 6 input cycles of it becoming valid.
- The two-slot capacity absorbs one full vector of consumer stall. Beyond that, words are dropped.
- All outputs are registered or decoded directly from registered state. There is no combinational path from in_* to out_*.
- out_ready → next out_valid is a combinational path through the full flags only.

## Structure
- Shared package holds:
  - LANES, WIDTH, VEC_W = LANES*WIDTH.
  - The lane-index width $clog2(LANES).
  - A slot-select enum {SLOT_A, SLOT_B}.
- Sub-module collector_slot:
  - Contents: one VEC_W register bank, per-lane write enable, and the full flag.
  - Ports: write-lane, set_full, clr_full.
  - Instantiated twice.
- The top level holds wsel/rsel/widx, the drop/flush/overflow logic and the output mux.

## Test plan
- Single vector: after reset, drive words 0x3F800000, 0x40000000 … 0x40C00000 on 6 consecutive cycles with out_ready=1 → out_valid one cycle after the 6th word. out_data[31:0]=0x3F800000 and out_data[191:160]=0x40C00000. overflow stays 0.
- Stall and double-buffer: out_ready=0 and 12 continuous words → out_valid holds vector 1 stable. When out_ready is raised for 2 cycles, vector 1 then vector 2 are delivered in order.
- Overflow: out_ready=0 and 13 words → the 13th word is dropped and overflow=1. When out_ready=1 and 6 more words are sent, vector 3 contains words 14–19. overflow_clr then clears overflow.
- Same-cycle release: both slots full, out_ready pulsed on the same cycle as word 13 → word 13 is accepted as lane 0 and overflow stays 0.
- Flush: 3 words, then flush together with in_valid (word discarded), then 6 new words → the output vector holds only the 6 new words. busy is 1 after the first word and 0 after the flush.
- Reset mid-fill: 4 words, then rst_n low for 1 cycle → all outputs return to reset values. The next 6 words form a clean vector.
